serial_sub: RTL
===============

Name: serial_sub

Overview:
- Bit-serial N-bit subtractor; the inverse of the full-adder datapath.
- Computes d = a − b − bi one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow.
- Used where a ripple subtractor's area is not affordable.
- Start/busy/done handshake toward the controlling logic; result held until the next operation.

Parameters:
- N, 4, operand width in bits (N ≥ 1).
- CW, $clog2(N+1), internal bit-counter width (derived, not to be overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  N  minuend, captured on accepted start
- b  input  N  subtrahend, captured on accepted start
- bi  input  1  borrow-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result becomes valid
- d  output  N  difference, registered
- bo  output  1  borrow-out, registered

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a rising clk edge with reset=1 → state=IDLE, busy=0, done=0, d=0, bo=0, shift registers and counter cleared. Reset has priority over all other inputs.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - capture a→sa, b→sb, bi→borrow register br; clear counter and result shift register sd
  - next=RUN.
- IDLE, start=0: hold all state.
- RUN, each cycle, full-subtractor cell on x=sa[0], y=sb[0], z=br:
  - diff = x^y^z
  - bout = (~x&y) | (~(x^y)&z)
- RUN register updates:
  - sa, sb shift right by 1
  - sd shifts right with diff entering at bit N-1
  - br ← bout; counter increments.
- RUN → DONE when the counter reaches N−1 on the current cycle, i.e. after exactly N RUN cycles. On that transition, d ← final sd value (including this cycle's diff) and bo ← bout.
- DONE: done=1 for exactly one cycle; next=IDLE.
- Latency: start sampled at edge k → busy high for cycles k+1..k+N → done high in cycle k+N+1. Total N+1 cycles to done.
- start while RUN or DONE: ignored, no effect on the operation in flight. Back-to-back throughput is one operation per N+2 cycles.
- d/bo hold their last value through IDLE and through a subsequent RUN. They change only on the RUN→DONE edge or on reset.
- Arithmetic: d = (a − b − bi) mod 2^N; bo=1 iff a < b + bi, as unsigned integers.
- N=1: single RUN cycle; identical in function to one full-subtractor cell.
- Reset asserted mid-RUN: operation aborted, no done pulse, outputs return to reset values.
- a/b/bi may change freely after the accepted start; they are don't-care outside that capture edge.

Decomposition:
- Shared package: state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2; full-subtractor truth relations as documented constants for the bench model.
- One combinational sub-module, fs (ports bi, a, b, bo, d), instanced once in the datapath. Same port shape as the existing full-adder cell, so it gets its own exhaustive 8-vector cell bench.
- Top: FSM, counter, three N-bit shift registers, borrow flop, output registers.

Test Plan:
- fs cell exhaustive: (bi,a,b) from 000 through 111 at 10 ns steps → (bo,d) = 00,11,01,00,11,10,00,11.
- N=4, a=7, b=3, bi=0, start one cycle → busy for 4 cycles, done pulse in 5th cycle after the start edge, d=4'h4, bo=0.
- N=4, a=3, b=7, bi=0 → d=4'hC, bo=1. Then a=0, b=0, bi=1 → d=4'hF, bo=1. Then a=15, b=15, bi=0 → d=0, bo=0.
- start held high continuously with changing a/b → only the operand present at each IDLE start edge is used. Results arrive every N+2=6 cycles; busy never drops mid-operation.
- reset pulsed at 2nd RUN cycle of a=9, b=2 → next cycle busy=0, d=0, bo=0, no done pulse. A new start afterwards completes correctly (a=9, b=2 → d=7, bo=0).
- Parameter sweep N=1 and N=8 against a reference model, 200 random (a,b,bi) each → every d/bo matches (a−b−bi) mod 2^N and the borrow rule; done latency = N+1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM encoding and the full-subtractor truth relations.
package serial_sub_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-subtractor truth tables, bit index = {bi, a, b}.
    //   d  = a ^ b ^ bi
    //   bo = (~a & b) | (~(a ^ b) & bi)
    localparam logic [7:0] FS_D_TT  = 8'h96;
    localparam logic [7:0] FS_BO_TT = 8'hB2;

endpackage

// File: rtl/fs.sv
// Single-bit full subtractor cell: d = a - b - bi, borrow out bo.
// Ports: bi/a/b single-bit inputs, bo borrow out, d difference bit.
module fs (
    input  logic bi,
    input  logic a,
    input  logic b,
    output logic bo,
    output logic d
);

    assign d  = a ^ b ^ bi;
    // Borrow when b exceeds a, or when a==b and a borrow comes in.
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, d = a - b - bi, LSB first, one bit/clock.
// Ports: clk, reset (sync, active-high), start, a, b, bi in; busy, done, d, bo out.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bo
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_n;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  sd;
    logic [N-1:0]  sd_n;
    logic          br;
    logic [CW-1:0] cnt;
    logic          diff;
    logic          bout;
    logic          last;

    fs u_fs (
        .bi (br),
        .a  (sa[0]),
        .b  (sb[0]),
        .bo (bout),
        .d  (diff)
    );

    assign last = (cnt == LAST);

    // Result shifts in from the top so the LSB lands at bit 0 after N steps.
    generate
        if (N == 1) begin : g_one
            assign sd_n = diff;
        end else begin : g_wide
            assign sd_n = {diff, sd[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa  <= '0;
            sb  <= '0;
            sd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
            d   <= '0;
            bo  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bi;
                        cnt <= '0;
                        sd  <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_n;
                    br  <= bout;
                    cnt <= cnt + CW'(1);
                    // Publish on the final bit; d/bo hold otherwise.
                    if (last) begin
                        d  <= sd_n;
                        bo <= bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
